// File: rtl/mux_arb_pkg.sv
// Shared arbitration types and helpers: FSM state enum, rotating first-set-bit
// search and a lane-slice macro for flattened multi-lane buses.
`ifndef MUX_ARB_LANE
`define MUX_ARB_LANE(vec, i, w) vec[(i)*(w) +: (w)]
`endif

package mux_arb_pkg;

    localparam int unsigned MAX_NWAY = 16;
    localparam int unsigned MAX_PW   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // First set bit at or after (ptr+1) mod n, wrapping; only indices < n are considered.
    function automatic logic [MAX_PW-1:0] rr_first(
        input logic [MAX_NWAY-1:0] req,
        input logic [MAX_PW-1:0]   ptr,
        input int unsigned         n
    );
        logic [MAX_PW-1:0] win;
        logic              found;
        int unsigned       cand;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_NWAY; k++) begin
            cand = (32'(ptr) + k) % n;
            if ((k <= n) && !found && req[MAX_PW'(cand)]) begin
                win   = MAX_PW'(cand);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mux_arb_nway_if.sv
// Master/slave channel bundle of the N-way arbitrated mux.
interface mux_arb_nway_if #(
    parameter int unsigned NWAY     = 4,
    parameter int unsigned DRIWIDTH = 32,
    parameter int unsigned RSPWIDTH = 32
) ();

    logic [NWAY-1:0]          req;
    logic [NWAY*DRIWIDTH-1:0] driveChan;
    logic [DRIWIDTH-1:0]      driveChanSlave;
    logic [RSPWIDTH-1:0]      respChanSlave;
    logic                     done;
    logic [NWAY*RSPWIDTH-1:0] respChan;
    logic [NWAY-1:0]          grant;
    logic                     busy;
    logic                     timeout;

    // Environment side: masters plus the shared slave.
    modport master (
        output req, driveChan, respChanSlave, done,
        input  driveChanSlave, respChan, grant, busy, timeout
    );

    // Arbiter side.
    modport slave (
        input  req, driveChan, respChanSlave, done,
        output driveChanSlave, respChan, grant, busy, timeout
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: winner is the first requester after ptr, with wrap.
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned NWAY = 4,
    parameter int unsigned PW   = $clog2(NWAY)
) (
    input  logic [NWAY-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner_c,
    output logic            valid_c
);

    always_comb begin
        winner_c = PW'(rr_first(MAX_NWAY'(req), MAX_PW'(ptr), NWAY));
        valid_c  = |req;
    end

endmodule

// File: rtl/mux_arb_nway.sv
// N-way arbitrated channel mux: round-robin grant held per transaction,
// released by slave done or by the watchdog.
module mux_arb_nway
    import mux_arb_pkg::*;
#(
    parameter int unsigned NWAY     = 4,
    parameter int unsigned DRIWIDTH = 32,
    parameter int unsigned RSPWIDTH = 32,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          rst,
    mux_arb_nway_if.slave bus
);

    localparam int unsigned   PW       = $clog2(NWAY);
    localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_e          state_q, state_d;
    logic [NWAY-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [PW-1:0]   win_c;
    logic            win_valid_c;

    rr_arbiter #(.NWAY(NWAY), .PW(PW)) u_rr (
        .req      (bus.req),
        .ptr      (ptr_q),
        .winner_c (win_c),
        .valid_c  (win_valid_c)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_valid_c) begin
                    state_d = BUSY;
                    grant_d = NWAY'(1) << win_c;
                    busy_d  = 1'b1;
                    idx_d   = win_c;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
                // done has priority over a coincident watchdog expiry
                if (bus.done || ((TIMEOUT != 0) && (cnt_q == CNT_LAST))) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = idx_q;
                    timeout_d = !bus.done;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= PW'(NWAY - 1);
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    // Lane routing follows the registered one-hot grant; no grant means all zeros.
    logic [DRIWIDTH-1:0]      drv_c;
    logic [NWAY*RSPWIDTH-1:0] rsp_c;

    always_comb begin
        drv_c = '0;
        rsp_c = '0;
        for (int i = 0; i < int'(NWAY); i++) begin
            if (grant_q[i]) begin
                drv_c                              = drv_c | `MUX_ARB_LANE(bus.driveChan, i, DRIWIDTH);
                `MUX_ARB_LANE(rsp_c, i, RSPWIDTH) = bus.respChanSlave;
            end
        end
    end

    assign bus.driveChanSlave = drv_c;
    assign bus.respChan       = rsp_c;
    assign bus.grant          = grant_q;
    assign bus.busy           = busy_q;
    assign bus.timeout        = timeout_q;

endmodule
